// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the memory-control datapath.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection between fetch and data requesters.
module mem_arb_picker
    import mem_ctrl_pkg::*;
(
    input  logic   i_if_req,
    input  logic   i_d_req,
    input  logic   i_streak_full,
    output owner_e o_winner,
    output logic   o_any_req
);

    // Data has priority unless fetch has waited through a full data streak
    always_comb begin
        o_any_req = i_if_req | i_d_req;
        if (i_d_req && !(i_if_req && i_streak_full)) begin
            o_winner = OWN_D;
        end else begin
            o_winner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between fetch and data requesters; one
// registered transaction at a time with ready/timeout completion.
module mem_bus_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_STREAK = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned SW    = $clog2(DATA_STREAK + 1);

    state_e            r_state, w_state_nxt;
    owner_e            r_owner, w_owner_nxt;
    logic [SW-1:0]     r_streak, w_streak_nxt;
    logic [CNT_W-1:0]  r_tcnt, w_tcnt_nxt;
    logic              r_if_gnt, w_if_gnt, r_d_gnt, w_d_gnt;
    logic              r_if_valid, w_if_valid, r_d_valid, w_d_valid;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata, r_d_rdata, w_d_rdata;
    logic              r_mem_req, w_mem_req, r_mem_we, w_mem_we;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
    logic              r_bus_err, w_bus_err;
    owner_e            w_winner;
    logic              w_any_req;
    logic              w_streak_full;

    assign w_streak_full = (r_streak == SW'(DATA_STREAK));

    mem_arb_picker u_picker (
        .i_if_req      (if_req),
        .i_d_req       (d_req),
        .i_streak_full (w_streak_full),
        .o_winner      (w_winner),
        .o_any_req     (w_any_req)
    );

    // Next-state and registered-output values for grant and completion
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_streak_nxt = r_streak;
        w_tcnt_nxt   = r_tcnt;
        w_if_gnt     = 1'b0;
        w_d_gnt      = 1'b0;
        w_if_valid   = 1'b0;
        w_d_valid    = 1'b0;
        w_if_rdata   = r_if_rdata;
        w_d_rdata    = r_d_rdata;
        w_mem_req    = r_mem_req;
        w_mem_we     = r_mem_we;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_bus_err    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ACCESS;
                    w_owner_nxt = w_winner;
                    w_mem_req   = 1'b1;
                    w_tcnt_nxt  = '0;
                    if (w_winner == OWN_D) begin
                        w_d_gnt     = 1'b1;
                        w_mem_we    = d_we;
                        w_mem_addr  = d_addr;
                        w_mem_wdata = d_wdata;
                        // Only count data grants that made fetch wait
                        if (!if_req) begin
                            w_streak_nxt = '0;
                        end else if (!w_streak_full) begin
                            w_streak_nxt = r_streak + SW'(1);
                        end
                    end else begin
                        w_if_gnt     = 1'b1;
                        w_mem_we     = 1'b0;
                        w_mem_addr   = if_addr;
                        w_mem_wdata  = '0;
                        w_streak_nxt = '0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    w_state_nxt = IDLE;
                    w_mem_req   = 1'b0;
                    w_tcnt_nxt  = '0;
                    if (r_owner == OWN_D) begin
                        w_d_valid = 1'b1;
                        w_d_rdata = r_mem_we ? '0 : mem_rdata;
                    end else begin
                        w_if_valid = 1'b1;
                        w_if_rdata = mem_rdata;
                    end
                end else if (r_tcnt == CNT_W'(TIMEOUT - 1)) begin
                    // This edge is the TIMEOUT-th access cycle without ready
                    w_state_nxt = IDLE;
                    w_mem_req   = 1'b0;
                    w_tcnt_nxt  = '0;
                    w_bus_err   = 1'b1;
                    if (r_owner == OWN_D) begin
                        w_d_valid = 1'b1;
                        w_d_rdata = '0;
                    end else begin
                        w_if_valid = 1'b1;
                        w_if_rdata = '0;
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_streak    <= '0;
            r_tcnt      <= '0;
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_streak    <= w_streak_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_if_gnt    <= w_if_gnt;
            r_d_gnt     <= w_d_gnt;
            r_if_valid  <= w_if_valid;
            r_d_valid   <= w_d_valid;
            r_if_rdata  <= w_if_rdata;
            r_d_rdata   <= w_d_rdata;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_bus_err   <= w_bus_err;
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_valid  = r_if_valid;
    assign if_rdata  = r_if_rdata;
    assign d_gnt     = r_d_gnt;
    assign d_valid   = r_d_valid;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign bus_err   = r_bus_err;
    assign busy      = (r_state == ACCESS);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Transaction-level self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

    localparam int unsigned DS = 4;
    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_gnt, if_valid, d_gnt, d_valid;
    logic        mem_req, mem_we, bus_err, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    mem_bus_arbiter #(
        .DATA_STREAK (DS),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: fetch-starvation count and last delivered words
    int          streak_m = 0;
    logic [31:0] if_rd_m  = '0;
    logic [31:0] d_rd_m   = '0;
    bit          obs_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = $urandom;
    endtask

    task automatic new_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
    endtask

    task automatic rand_d();
        new_d(1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    // One IDLE cycle with nobody requesting
    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_mem_req", {31'b0, mem_req}, 32'd0);
        check("idle_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
        check("idle_valid", {30'b0, if_valid, d_valid}, 32'd0);
    endtask

    // Called at a negedge in IDLE with at least one request raised. lat is the
    // access cycle on which memory answers; beyond TO the access times out.
    // rereq: 0 never, 1 random, 2 always re-raise the winner during access.
    task automatic run_txn(input int lat, input int rereq, input logic [31:0] rdv);
        bit          d_wins, err;
        logic        exp_we;
        logic [31:0] exp_a, exp_wd, rd;
        int          endk;
        d_wins = d_req && !(if_req && streak_m == int'(DS));
        if (d_wins) begin
            streak_m = if_req ? ((streak_m < int'(DS)) ? streak_m + 1 : int'(DS)) : 0;
            exp_we   = d_we;
            exp_a    = d_addr;
            exp_wd   = d_wdata;
        end else begin
            streak_m = 0;
            exp_we   = 1'b0;
            exp_a    = if_addr;
            exp_wd   = '0;
        end
        endk = (lat < int'(TO)) ? lat : int'(TO);
        err  = (lat > int'(TO));
        rd   = '0;

        @(posedge clk);
        @(negedge clk);
        obs_d = d_gnt;
        check("if_gnt", {31'b0, if_gnt}, {31'b0, !d_wins});
        check("d_gnt", {31'b0, d_gnt}, {31'b0, d_wins});
        check("grant_mem_req", {31'b0, mem_req}, 32'd1);
        check("grant_busy", {31'b0, busy}, 32'd1);
        check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        check("mem_addr", mem_addr, exp_a);
        if (d_wins) check("mem_wdata", mem_wdata, exp_wd);

        // Winner drops its request; new fields must not disturb the latched ones
        if (d_wins) begin
            if (rereq == 2 || (rereq == 1 && $urandom_range(0, 1) == 1)) rand_d();
            else begin
                d_req   = 1'b0;
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
        end else begin
            if (rereq == 2 || (rereq == 1 && $urandom_range(0, 1) == 1)) new_if();
            else begin
                if_req  = 1'b0;
                if_addr = $urandom;
            end
        end

        for (int k = 1; k <= endk; k++) begin
            if (k > 1) begin
                check("acc_mem_req", {31'b0, mem_req}, 32'd1);
                check("acc_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
                check("acc_valid", {30'b0, if_valid, d_valid}, 32'd0);
                check("acc_addr", mem_addr, exp_a);
                check("acc_we", {31'b0, mem_we}, {31'b0, exp_we});
            end
            mem_ready = (k == lat);
            mem_rdata = (k == lat) ? rdv : $urandom;
            rd        = mem_rdata;
            @(posedge clk);
            @(negedge clk);
        end

        if (d_wins) d_rd_m = (err || exp_we) ? 32'd0 : rd;
        else if_rd_m = err ? 32'd0 : rd;
        check("if_valid", {31'b0, if_valid}, {31'b0, !d_wins});
        check("d_valid", {31'b0, d_valid}, {31'b0, d_wins});
        check("bus_err", {31'b0, bus_err}, {31'b0, err});
        check("done_mem_req", {31'b0, mem_req}, 32'd0);
        check("done_busy", {31'b0, busy}, 32'd0);
        check("done_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
        check("if_rdata", if_rdata, if_rd_m);
        check("d_rdata", d_rdata, d_rd_m);
        // Ready during IDLE must be ignored
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        check("rst_outputs", {25'b0, if_gnt, if_valid, d_gnt, d_valid, mem_req, bus_err, busy},
              32'd0);
        check("rst_rdata", if_rdata | d_rdata | mem_addr | mem_wdata, 32'd0);
        rst = 1'b0;
        idle_cycle();

        // Load answered on the second access cycle
        new_d(1'b0, 32'h100, 32'h0);
        run_txn(2, 0, 32'hDEADBEEF);
        check("load_word", d_rdata, 32'hDEADBEEF);

        // Store: write strobe and data visible, response carries zero
        new_d(1'b1, 32'h40, 32'h12345678);
        run_txn(3, 0, 32'hFFFF0000);

        // Fetch timeout and fetch with ready on the timeout edge
        new_if();
        run_txn(int'(TO) + 5, 0, 32'h0);
        new_if();
        run_txn(int'(TO), 0, 32'hA5A55A5A);
        check("coincide_word", if_rdata, 32'hA5A55A5A);

        // Both requesters held continuously: D,D,D,D,IF repeating
        new_if();
        run_txn(1, 0, $urandom);
        new_if();
        rand_d();
        for (int i = 0; i < 10; i++) begin
            run_txn(1, 2, $urandom);
            check("streak_order", {31'b0, obs_d}, {31'b0, (i % 5) != 4});
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        // The pending loser was granted after the drop above? No: both dropped here.
        idle_cycle();

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            if (!if_req && $urandom_range(0, 2) == 0) new_if();
            if (!d_req && $urandom_range(0, 1) == 0) rand_d();
            if (!if_req && !d_req) begin
                if ($urandom_range(0, 1) == 1) idle_cycle();
                if ($urandom_range(0, 1) == 1) new_if();
                else rand_d();
            end
            run_txn(($urandom_range(0, 5) == 0) ? int'(TO) + 1 + int'($urandom_range(0, 2))
                                               : int'($urandom_range(1, TO)), 1, $urandom);
        end

        // Reset in the middle of an access
        if_req = 1'b0;
        new_d(1'b0, 32'h200, 32'h0);
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_gnt", {31'b0, d_gnt}, 32'd1);
        d_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_async_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_async_busy", {31'b0, busy}, 32'd0);
        check("rst_async_gv", {28'b0, if_gnt, d_gnt, if_valid, d_valid}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        streak_m = 0;
        if_rd_m  = '0;
        d_rd_m   = '0;
        check("rst_d_rdata", d_rdata, 32'd0);
        idle_cycle();
        new_if();
        run_txn(3, 0, 32'hCAFEF00D);
        check("post_rst_word", if_rdata, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
